// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared state encodings, command/error codes and checksum helper
package uart_frame_pkg;

  typedef enum logic [2:0] {
    ST_HUNT = 3'd0,
    ST_CMD  = 3'd1,
    ST_ADDR = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WRITE         = 8'h01;
  localparam logic [7:0] CMD_READ          = 8'h02;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_CMD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  function automatic logic [7:0] frame_csum(input logic [7:0] cmd,
                                            input logic [7:0] addr,
                                            input logic [7:0] data);
    return cmd ^ addr ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_timeout.sv
// rtl/uart_frame_timeout.sv - inter-byte idle counter, flags the last allowed idle clock
module uart_frame_timeout #(
  parameter int TIMEOUT_CLKS = 8700
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Timeout
);

  localparam int              W       = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [W-1:0]    LP_LAST = W'(TIMEOUT_CLKS - 1);

  logic [W-1:0] r_Count;

  // Holding at LP_LAST keeps the counter from wrapping if the owner ignores the flag.
  always_ff @(posedge i_Clock) begin
    if (i_Reset || i_Clear || !i_Enable) begin
      r_Count <= '0;
    end else if (r_Count != LP_LAST) begin
      r_Count <= r_Count + W'(1);
    end
  end

  assign o_Timeout = i_Enable && (r_Count == LP_LAST);

endmodule

// File: rtl/uart_frame_decoder.sv
// rtl/uart_frame_decoder.sv - assembles and validates 5-byte UART command frames
module uart_frame_decoder
  import uart_frame_pkg::*;
#(
  parameter int         TIMEOUT_CLKS = 8700,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Wr_En,
  output logic       o_Rd_En,
  output logic [7:0] o_Addr,
  output logic [7:0] o_Data,
  output logic       o_Err,
  output logic [1:0] o_Err_Code,
  output logic [7:0] o_Err_Count,
  output logic       o_Busy
);

  state_t     r_State;
  logic [7:0] r_Cmd;
  logic [7:0] r_Addr_Sh;
  logic [7:0] r_Data_Sh;
  logic [7:0] r_Addr;
  logic [7:0] r_Data;
  logic       r_Wr_En;
  logic       r_Rd_En;
  logic       r_Err;
  logic [1:0] r_Err_Code;
  logic [7:0] r_Err_Count;

  logic       w_Timeout;
  logic       w_Tmo_Hit;
  logic       w_Cmd_Bad;
  logic       w_Csum_Bad;
  logic       w_Err_Fire;
  logic [1:0] w_Err_Code;

  uart_frame_timeout #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_timeout (
    .i_Clock  (i_Clock),
    .i_Reset  (i_Reset),
    .i_Clear  (i_Rx_DV || w_Timeout),
    .i_Enable (r_State != ST_HUNT),
    .o_Timeout(w_Timeout)
  );

  // A byte landing on the last idle clock still counts, so it masks the timeout.
  always_comb begin
    w_Tmo_Hit  = w_Timeout && !i_Rx_DV;
    w_Cmd_Bad  = (r_State == ST_CMD) && i_Rx_DV &&
                 (i_Rx_Byte != CMD_WRITE) && (i_Rx_Byte != CMD_READ);
    w_Csum_Bad = (r_State == ST_CSUM) && i_Rx_DV &&
                 (i_Rx_Byte != frame_csum(r_Cmd, r_Addr_Sh, r_Data_Sh));
    w_Err_Fire = w_Tmo_Hit || w_Cmd_Bad || w_Csum_Bad;
    w_Err_Code = 2'b00;
    if (w_Tmo_Hit)       w_Err_Code = ERR_TIMEOUT;
    else if (w_Cmd_Bad)  w_Err_Code = ERR_CMD;
    else if (w_Csum_Bad) w_Err_Code = ERR_CSUM;
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_State     <= ST_HUNT;
      r_Cmd       <= '0;
      r_Addr_Sh   <= '0;
      r_Data_Sh   <= '0;
      r_Addr      <= '0;
      r_Data      <= '0;
      r_Wr_En     <= 1'b0;
      r_Rd_En     <= 1'b0;
      r_Err       <= 1'b0;
      r_Err_Code  <= '0;
      r_Err_Count <= '0;
    end else begin
      r_Wr_En <= 1'b0;
      r_Rd_En <= 1'b0;
      r_Err   <= w_Err_Fire;
      if (w_Err_Fire) begin
        r_Err_Code <= w_Err_Code;
        if (r_Err_Count != 8'hFF) r_Err_Count <= r_Err_Count + 8'd1;
      end
      if (w_Tmo_Hit) begin
        r_State <= ST_HUNT;
      end else if (i_Rx_DV) begin
        case (r_State)
          ST_HUNT: begin
            if (i_Rx_Byte == SYNC_BYTE) r_State <= ST_CMD;
          end
          ST_CMD: begin
            if (w_Cmd_Bad) begin
              r_State <= ST_HUNT;
            end else begin
              r_Cmd   <= i_Rx_Byte;
              r_State <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            r_Addr_Sh <= i_Rx_Byte;
            r_State   <= ST_DATA;
          end
          ST_DATA: begin
            r_Data_Sh <= i_Rx_Byte;
            r_State   <= ST_CSUM;
          end
          ST_CSUM: begin
            r_State <= ST_HUNT;
            if (!w_Csum_Bad) begin
              r_Addr  <= r_Addr_Sh;
              r_Data  <= r_Data_Sh;
              r_Wr_En <= (r_Cmd == CMD_WRITE);
              r_Rd_En <= (r_Cmd == CMD_READ);
            end
          end
          default: r_State <= ST_HUNT;
        endcase
      end
    end
  end

  assign o_Wr_En     = r_Wr_En;
  assign o_Rd_En     = r_Rd_En;
  assign o_Addr      = r_Addr;
  assign o_Data      = r_Data;
  assign o_Err       = r_Err;
  assign o_Err_Code  = r_Err_Code;
  assign o_Err_Count = r_Err_Count;
  assign o_Busy      = (r_State != ST_HUNT);

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb/tb_uart_frame_decoder.sv - self-checking bench: vector table, directed corners, random frames vs model
module tb_uart_frame_decoder;

  localparam int         T    = 8700;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       i_Clock = 1'b0;
  logic       i_Reset;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic       o_Wr_En;
  logic       o_Rd_En;
  logic [7:0] o_Addr;
  logic [7:0] o_Data;
  logic       o_Err;
  logic [1:0] o_Err_Code;
  logic [7:0] o_Err_Count;
  logic       o_Busy;

  always #5 i_Clock = ~i_Clock;

  uart_frame_decoder #(
    .TIMEOUT_CLKS(T),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .i_Clock    (i_Clock),
    .i_Reset    (i_Reset),
    .i_Rx_DV    (i_Rx_DV),
    .i_Rx_Byte  (i_Rx_Byte),
    .o_Wr_En    (o_Wr_En),
    .o_Rd_En    (o_Rd_En),
    .o_Addr     (o_Addr),
    .o_Data     (o_Data),
    .o_Err      (o_Err),
    .o_Err_Code (o_Err_Code),
    .o_Err_Count(o_Err_Count),
    .o_Busy     (o_Busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc_n = 0;

  // Reference model: the bytes of the frame in progress plus idle time since the last byte.
  logic [7:0] m_frame[$];
  int         m_idle;
  logic       m_wr, m_rd, m_err, m_busy;
  logic [7:0] m_addr, m_data, m_count;
  logic [1:0] m_code;

  typedef struct {
    logic [39:0] bytes;
    int          nb;
    int          gap;
    int          kind;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [1:0]  code;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_idle  = 0;
    m_wr    = 1'b0;
    m_rd    = 1'b0;
    m_err   = 1'b0;
    m_busy  = 1'b0;
    m_addr  = 8'h00;
    m_data  = 8'h00;
    m_count = 8'h00;
    m_code  = 2'b00;
  endtask

  task automatic model_error(input logic [1:0] c);
    m_err  = 1'b1;
    m_code = c;
    if (m_count != 8'hFF) m_count = m_count + 8'd1;
    m_frame.delete();
  endtask

  task automatic model_step(input logic dv, input logic [7:0] b);
    m_wr  = 1'b0;
    m_rd  = 1'b0;
    m_err = 1'b0;
    if (m_frame.size() == 0) begin
      if (dv && b == SYNC) m_frame.push_back(b);
      m_idle = 0;
    end else if (dv) begin
      m_frame.push_back(b);
      m_idle = 0;
      if (m_frame.size() == 2 && b != 8'h01 && b != 8'h02) begin
        model_error(2'b10);
      end else if (m_frame.size() == 5) begin
        if ((m_frame[1] ^ m_frame[2] ^ m_frame[3]) == b) begin
          m_addr = m_frame[2];
          m_data = m_frame[3];
          m_wr   = (m_frame[1] == 8'h01);
          m_rd   = (m_frame[1] == 8'h02);
        end else begin
          model_error(2'b01);
        end
        m_frame.delete();
      end
    end else if (m_idle == T - 1) begin
      model_error(2'b11);
    end else begin
      m_idle++;
    end
    m_busy = (m_frame.size() != 0);
  endtask

  task automatic compare_all();
    int s;
    s = int'(o_Wr_En) + int'(o_Rd_En) + int'(o_Err);
    check("wr_en",     32'(o_Wr_En),     32'(m_wr));
    check("rd_en",     32'(o_Rd_En),     32'(m_rd));
    check("err",       32'(o_Err),       32'(m_err));
    check("busy",      32'(o_Busy),      32'(m_busy));
    check("addr",      32'(o_Addr),      32'(m_addr));
    check("data",      32'(o_Data),      32'(m_data));
    check("err_code",  32'(o_Err_Code),  32'(m_code));
    check("err_count", 32'(o_Err_Count), 32'(m_count));
    check("exclusive", 32'(s <= 1),      32'(1));
  endtask

  task automatic cyc(input logic dv, input logic [7:0] b);
    i_Rx_DV   = dv;
    i_Rx_Byte = b;
    @(posedge i_Clock);
    cyc_n++;
    model_step(dv, b);
    @(negedge i_Clock);
    compare_all();
    i_Rx_DV = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 8'($urandom));
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    i_Rx_DV = 1'b0;
    @(posedge i_Clock);
    cyc_n++;
    model_reset();
    @(negedge i_Clock);
    compare_all();
    i_Reset = 1'b0;
  endtask

  initial begin
    int t1, t2;
    logic [7:0] c, a, d, s;
    int r;

    i_Reset   = 1'b1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'h00;
    model_reset();
    repeat (2) @(negedge i_Clock);
    do_reset();
    check("rst_busy",  32'(o_Busy),      32'(0));
    check("rst_count", 32'(o_Err_Count), 32'(0));
    check("rst_addr",  32'(o_Addr),      32'(0));

    vecs[0] = '{40'hA501105A4B, 5, 869, 1, 8'h10, 8'h5A, 2'b00, 8'd0};
    vecs[1] = '{40'hA502200022, 5, 3,   2, 8'h20, 8'h00, 2'b00, 8'd0};
    vecs[2] = '{40'hA501334400, 5, 1,   3, 8'h20, 8'h00, 2'b01, 8'd1};
    vecs[3] = '{40'h1122A50700, 4, 2,   3, 8'h20, 8'h00, 2'b10, 8'd2};
    vecs[4] = '{40'hA501010101, 5, 0,   1, 8'h01, 8'h01, 2'b10, 8'd2};

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < vecs[v].nb; i++) begin
        send(vecs[v].bytes[39-8*i -: 8]);
        if (i != vecs[v].nb - 1) idle(vecs[v].gap);
      end
      check($sformatf("vec%0d_wr", v),    32'(o_Wr_En),     32'(vecs[v].kind == 1));
      check($sformatf("vec%0d_rd", v),    32'(o_Rd_En),     32'(vecs[v].kind == 2));
      check($sformatf("vec%0d_err", v),   32'(o_Err),       32'(vecs[v].kind == 3));
      check($sformatf("vec%0d_addr", v),  32'(o_Addr),      32'(vecs[v].addr));
      check($sformatf("vec%0d_data", v),  32'(o_Data),      32'(vecs[v].data));
      check($sformatf("vec%0d_code", v),  32'(o_Err_Code),  32'(vecs[v].code));
      check($sformatf("vec%0d_count", v), 32'(o_Err_Count), 32'(vecs[v].cnt));
      idle(2);
    end

    // Timeout fires on the T-th idle clock after entering ADDR.
    send(SYNC); send(8'h01);
    idle(T - 1);
    check("tmo_early_err",  32'(o_Err),       32'(0));
    check("tmo_early_busy", 32'(o_Busy),      32'(1));
    idle(1);
    check("tmo_err",        32'(o_Err),       32'(1));
    check("tmo_code",       32'(o_Err_Code),  32'(3));
    check("tmo_busy",       32'(o_Busy),      32'(0));
    check("tmo_count",      32'(o_Err_Count), 32'(3));

    send(SYNC); send(8'h01);
    idle(T - 1);
    send(8'h10);
    check("tmo_dv_err",  32'(o_Err),  32'(0));
    check("tmo_dv_busy", 32'(o_Busy), 32'(1));
    send(8'h5A); send(8'h4B);
    check("tmo_dv_wr",   32'(o_Wr_En), 32'(1));
    check("tmo_dv_addr", 32'(o_Addr),  32'(8'h10));

    // Back-to-back frames on consecutive cycles.
    idle(2);
    send(SYNC); send(8'h01); send(8'h22); send(8'h33); send(8'h10);
    t1 = cyc_n;
    check("b2b_wr", 32'(o_Wr_En), 32'(1));
    send(SYNC); send(8'h02); send(8'h44); send(8'h55); send(8'h13);
    t2 = cyc_n;
    check("b2b_rd",      32'(o_Rd_En), 32'(1));
    check("b2b_data",    32'(o_Data),  32'(8'h55));
    check("b2b_spacing", 32'(t2 - t1), 32'(5));

    for (int k = 0; k < 260; k++) begin
      send(SYNC); send(8'h07);
    end
    check("sat_count", 32'(o_Err_Count), 32'(8'hFF));
    check("sat_code",  32'(o_Err_Code),  32'(2));

    send(SYNC); send(8'h01); send(8'h10);
    do_reset();
    check("midrst_count", 32'(o_Err_Count), 32'(0));
    check("midrst_busy",  32'(o_Busy),      32'(0));
    check("midrst_wr",    32'(o_Wr_En),     32'(0));
    send(8'h5A); send(8'h4B);
    check("midrst_tail_wr", 32'(o_Wr_En), 32'(0));
    send(SYNC); send(8'h01); send(8'h10); send(8'h5A); send(8'h4B);
    check("post_rst_wr",   32'(o_Wr_En), 32'(1));
    check("post_rst_data", 32'(o_Data),  32'(8'h5A));

    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) send(8'($urandom_range(0, 8'hA4)));
      c = (r < 4) ? 8'h01 : (r < 7) ? 8'h02 : 8'($urandom);
      a = 8'($urandom);
      d = 8'($urandom);
      s = c ^ a ^ d;
      if (r == 8) s = s ^ 8'(1 << $urandom_range(0, 7));
      send(SYNC); idle($urandom_range(0, 3));
      send(c);    idle($urandom_range(0, 3));
      send(a);    idle($urandom_range(0, 3));
      send(d);    idle($urandom_range(0, 3));
      send(s);    idle($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
